// File: rtl/regdump_pkg.sv
// Shared types and default dimensions for the register-file dump reader.
package regdump_pkg;

   localparam int unsigned NUM_REGS_DEF = 32;
   localparam int unsigned ADDR_W_DEF   = 5;
   localparam int unsigned DATA_W_DEF   = 32;

   // The checksum beat carries this address so it never aliases a real index
   // in a way downstream could misread (out_last disambiguates it).
   localparam logic [ADDR_W_DEF-1:0] CSUM_ADDR = 5'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_CSUM = 2'd3
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Read-port and stream bundle between the dump reader, the register file
// and the debug link.
interface regfile_dump_reader_if
   import regdump_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;

   modport master (
      output rd_addr,
      input  rd_data,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_addr,
      output out_last
   );

   modport slave (
      input  rd_addr,
      output rd_data,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_addr,
      input  out_last
   );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file through its debug read port and streams every word
// out; REGDUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dump_reader
   import regdump_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  start,
   input  logic                  abort,
   output logic                  freeze,
   output logic                  done,
   regfile_dump_reader_if.master bus
);

   localparam int unsigned PTR_W = ADDR_W + 1;

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_LOAD = ST_LOAD;
   localparam logic [1:0] S_SEND = ST_SEND;
`ifdef REGDUMP_CHECKSUM_EN
   localparam logic [1:0] S_CSUM = ST_CSUM;
`endif

   logic [1:0]        state_q,     state_d;
   logic [PTR_W-1:0]  ptr_q,       ptr_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q,  out_last_d;
   logic              freeze_q,    freeze_d;
   logic              done_q,      done_d;
`ifdef REGDUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q,      csum_d;
`endif

   logic handshake;
   logic beat_is_final_reg;
   logic ptr_is_last_reg;

   // Next-state, pointer, capture and checksum logic.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      handshake         = out_valid_q & bus.out_ready;
      beat_is_final_reg = (out_addr_q == ADDR_W'(NUM_REGS - 1));
`ifdef REGDUMP_CHECKSUM_EN
      ptr_is_last_reg   = 1'b0;
`else
      // Without a checksum beat, the last register beat closes the dump.
      ptr_is_last_reg   = (ptr_q == PTR_W'(NUM_REGS - 1));
`endif

      case (state_q)
         S_IDLE: begin
            ptr_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_d      = '0;
`endif
            if (start) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            out_data_d  = bus.rd_data;
            out_addr_d  = ptr_q[ADDR_W-1:0];
            out_last_d  = ptr_is_last_reg;
            ptr_d       = ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (handshake) begin
`ifdef REGDUMP_CHECKSUM_EN
               csum_d = csum_q ^ out_data_q;
`endif
               if (beat_is_final_reg) begin
`ifdef REGDUMP_CHECKSUM_EN
                  state_d    = S_CSUM;
                  out_data_d = csum_q ^ out_data_q;
                  out_addr_d = ADDR_W'(CSUM_ADDR);
                  out_last_d = 1'b1;
`else
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
`endif
               end else begin
                  out_data_d = bus.rd_data;
                  out_addr_d = ptr_q[ADDR_W-1:0];
                  out_last_d = ptr_is_last_reg;
                  ptr_d      = ptr_q + PTR_W'(1);
               end
            end else begin
               state_d = S_SEND;
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         S_CSUM: begin
            if (handshake) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               done_d      = 1'b1;
            end else begin
               state_d = S_CSUM;
            end
         end
`endif
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      endcase

      // Abort overrides everything outside IDLE and never pulses done.
      if (abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         done_d      = 1'b0;
      end else begin
         state_d = state_d;
      end

      freeze_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         freeze_q    <= 1'b0;
         done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         freeze_q    <= freeze_d;
         done_q      <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.rd_addr   = ptr_q[ADDR_W-1:0];
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_last  = out_last_q;
   assign freeze        = freeze_q;
   assign done          = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed-plus-random bench for regfile_dump_reader; expected beats come from
// a queue built from the register contents (checksum beat with REGDUMP_CHECKSUM_EN).
module tb_regfile_dump_reader;

   localparam int NREG = 32;

   logic clk;
   logic rstb;
   logic start;
   logic abort;
   logic ready;
   logic freeze;
   logic done;

   logic [31:0] regs [NREG];

   logic [31:0] exp_data [$];
   int          exp_addr [$];
   bit          exp_last [$];

   int checks;
   int errors;

   regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   assign bus.rd_data   = regs[bus.rd_addr];
   assign bus.out_ready = ready;

   regfile_dump_reader dut (
      .clk    (clk),
      .rstb   (rstb),
      .start  (start),
      .abort  (abort),
      .freeze (freeze),
      .done   (done),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, ".valid"},  32'(bus.out_valid), 32'd0);
      check({nm, ".data"},   bus.out_data,       32'd0);
      check({nm, ".addr"},   32'(bus.out_addr),  32'd0);
      check({nm, ".last"},   32'(bus.out_last),  32'd0);
      check({nm, ".rdaddr"}, 32'(bus.rd_addr),   32'd0);
      check({nm, ".freeze"}, 32'(freeze),        32'd0);
      check({nm, ".done"},   32'(done),          32'd0);
   endtask

   // Expected beat list: every register in order, then the XOR word if enabled.
   function automatic void build_exp();
      logic [31:0] x;
      x = 32'd0;
      exp_data.delete();
      exp_addr.delete();
      exp_last.delete();
      for (int k = 0; k < NREG; k++) begin
         exp_data.push_back(regs[k]);
         exp_addr.push_back(k);
         exp_last.push_back(1'b0);
         x = x ^ regs[k];
      end
`ifdef REGDUMP_CHECKSUM_EN
      exp_data.push_back(x);
      exp_addr.push_back(0);
      exp_last.push_back(1'b1);
`else
      exp_last[NREG-1] = 1'b1;
`endif
   endfunction

   // Called at a falling edge; raises start there so the next rising edge samples it.
   task automatic dump(input int rmode, input int abort_at, input int mstart_at,
                       input int rst_at, input bit full_rate, input string nm);
      int idx;
      int cyc;
      bit fin;
      bit aborting;
      bit resetting;
      build_exp();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({nm, ".load_valid"},  32'(bus.out_valid), 32'd0);
      check({nm, ".load_freeze"}, 32'(freeze),        32'd1);
      idx = 0;
      cyc = 0;
      fin = 1'b0;
      aborting = 1'b0;
      resetting = 1'b0;
      while (!fin && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         check({nm, ".valid"},  32'(bus.out_valid), 32'd1);
         check({nm, ".freeze"}, 32'(freeze),        32'd1);
         check({nm, ".done"},   32'(done),          32'd0);
         check($sformatf("%s.data[%0d]", nm, idx), bus.out_data,      exp_data[idx]);
         check($sformatf("%s.addr[%0d]", nm, idx), 32'(bus.out_addr), 32'(exp_addr[idx]));
         check($sformatf("%s.last[%0d]", nm, idx), 32'(bus.out_last), 32'(exp_last[idx]));
         abort = 1'b0;
         start = 1'b0;
         if (idx == abort_at) begin
            abort = 1'b1;
            ready = 1'b0;
            aborting = 1'b1;
            fin = 1'b1;
         end else if (idx == rst_at) begin
            ready = 1'b0;
            rstb = 1'b0;
            #1;
            check_all_zero({nm, ".async_rst"});
            resetting = 1'b1;
            fin = 1'b1;
         end else begin
            case (rmode)
               0: ready = 1'b1;
               1: ready = ((cyc % 2) == 0);
               default: ready = 1'($urandom_range(0, 1));
            endcase
            if (idx == mstart_at) start = 1'b1;
            if (ready) begin
               idx++;
               if (idx == exp_data.size()) fin = 1'b1;
            end
         end
      end
      if (!fin) check({nm, ".timeout"}, 32'd1, 32'd0);
      if (fin && full_rate && !aborting && !resetting)
         check({nm, ".cycles"}, 32'(cyc), 32'(exp_data.size()));
      if (!resetting) begin
         @(negedge clk);
         abort = 1'b0;
         start = 1'b0;
         check({nm, ".post_valid"},  32'(bus.out_valid), 32'd0);
         check({nm, ".post_freeze"}, 32'(freeze),        32'd0);
         check({nm, ".post_done"},   32'(done),          aborting ? 32'd0 : 32'd1);
         if (!aborting) check({nm, ".beats"}, 32'(idx), 32'(exp_data.size()));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstb   = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      ready  = 1'b0;
      for (int k = 0; k < NREG; k++) regs[k] = 32'h1000_0000 + 32'(k);

      repeat (2) @(negedge clk);
      check_all_zero("in_reset");
      rstb = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("idle");

      dump(0, -1, -1, -1, 1'b1, "seq");
      @(negedge clk);
      check("idle_done_low", 32'(done), 32'd0);

      for (int k = 0; k < NREG; k++) regs[k] = $urandom;
      dump(1, -1, -1, -1, 1'b0, "toggle");
      @(negedge clk);
      dump(2, -1, -1, -1, 1'b0, "rand");
      @(negedge clk);

      dump(0, 10, -1, -1, 1'b0, "abort");
      @(negedge clk);
      check("abort_done_stays_low", 32'(done), 32'd0);
      dump(0, -1, -1, -1, 1'b1, "restart");
      @(negedge clk);

      dump(0, -1, 7, -1, 1'b1, "midstart");
      @(negedge clk);

      for (int k = 0; k < NREG; k++) regs[k] = $urandom;
      dump(0, -1, -1, 5, 1'b0, "reset");
      @(negedge clk);
      check_all_zero("held_rst");
      rstb = 1'b1;
      @(negedge clk);
      dump(2, -1, -1, -1, 1'b0, "post_rst");
      @(negedge clk);

      dump(0, -1, -1, -1, 1'b1, "b2b_a");
      dump(0, -1, -1, -1, 1'b1, "b2b_b");
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
